// File: rtl/adc_spi_sampler_if.sv
// Signal bundle between the sampler and its surroundings: conversion control,
// the SPI pins towards the ADC and the sample stream towards the filter.
interface adc_spi_sampler_if;
    logic       en_i;
    logic [2:0] channel_i;
    logic       miso_i;
    logic       sclk_o;
    logic       mosi_o;
    logic       cs_no;
    logic [9:0] signal_o;
    logic       sample_o;
    logic       overrun_o;

    // Sampler side
    modport master (
        input  en_i, channel_i, miso_i,
        output sclk_o, mosi_o, cs_no, signal_o, sample_o, overrun_o
    );

    // Environment side (controller, ADC pins, downstream filter)
    modport slave (
        output en_i, channel_i, miso_i,
        input  sclk_o, mosi_o, cs_no, signal_o, sample_o, overrun_o
    );
endinterface

// File: rtl/adc_spi_sampler.sv
// Paced MCP3008-style acquisition: one 16-SCLK SPI frame per sample tick,
// result presented on signal_o with a single-cycle sample_o strobe.
module adc_spi_sampler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SAMPLE_DIV = 2500
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    adc_spi_sampler_if.master  bus
);

    localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DW = $clog2(CLK_DIV);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StShift = 3'd2;
    localparam logic [2:0] StHold  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [TW-1:0] timer_q;
    logic          tick;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [2:0]    ch_q, ch_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic [9:0]    signal_q, signal_d;
    logic          sample_q, sample_d;
    logic          overrun_q, overrun_d;
    logic          div_end;

    // Command bit n (1-based): start, single-ended, ch[2:0], then zeros.
    function automatic logic frame_bit(input logic [4:0] n, input logic [2:0] ch);
        case (n)
            5'd1, 5'd2: frame_bit = 1'b1;
            5'd3:       frame_bit = ch[2];
            5'd4:       frame_bit = ch[1];
            5'd5:       frame_bit = ch[0];
            default:    frame_bit = 1'b0;
        endcase
    endfunction

    assign tick    = bus.en_i && (timer_q == TW'(SAMPLE_DIV - 1));
    assign div_end = (div_q == DW'(CLK_DIV - 1));

    // Sample-rate timer, held at zero while disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (!bus.en_i || tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Frame sequencing, SCLK/MOSI generation and MISO capture.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        ch_d      = ch_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        signal_d  = signal_q;
        sample_d  = 1'b0;
        overrun_d = overrun_q;

        // A tick outside IDLE is dropped and only flagged.
        if (tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
        if (!bus.en_i) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    ch_d    = bus.channel_i;
                    mosi_d  = frame_bit(5'd1, bus.channel_i);
                    shreg_d = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            StSetup: begin
                if (div_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (!div_end) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the bit for the next rising edge.
                        sclk_d = 1'b0;
                        mosi_d = frame_bit({1'b0, bit_q} + 5'd2, ch_q);
                    end else if (bit_q == 4'd15) begin
                        state_d = StHold;
                    end else begin
                        // Rising edge number bit_q+2; data bits arrive on edges 7..16.
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                        if (bit_q >= 4'd5) begin
                            shreg_d = {shreg_q[8:0], bus.miso_i};
                        end
                    end
                end
            end
            StHold: begin
                if (div_end) begin
                    div_d    = '0;
                    state_d  = StDone;
                    cs_n_d   = 1'b1;
                    mosi_d   = 1'b0;
                    sample_d = 1'b1;
                    signal_d = shreg_q;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            ch_q      <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            signal_q  <= '0;
            sample_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            ch_q      <= ch_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            signal_q  <= signal_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sclk_o    = sclk_q;
    assign bus.mosi_o    = mosi_q;
    assign bus.cs_no     = cs_n_q;
    assign bus.signal_o  = signal_q;
    assign bus.sample_o  = sample_q;
    assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: two instances (default rate and a fast rate that
// forces overruns), ADC pin models, a timeline model and directed scenarios.
module tb_adc_spi_sampler;

    localparam int D   = 4;
    localparam int SD0 = 2500;
    localparam int SD1 = 100;
    localparam int FL  = 34 * D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en [2];
    logic [2:0] ch [2];
    logic [9:0] adc_val [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adc_spi_sampler_if bus0 ();
    adc_spi_sampler_if bus1 ();

    assign bus0.en_i      = en[0];
    assign bus0.channel_i = ch[0];
    assign bus1.en_i      = en[1];
    assign bus1.channel_i = ch[1];

    adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_DIV(SD0)) u_dut0 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus0)
    );

    adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_DIV(SD1)) u_dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus1)
    );

    // ADC pin models: count SCLK rises per frame, record MOSI on rises,
    // and shift MISO on falling edges (null bit after edge 5, data on 7..16).
    int   rises0 = 0, rises1 = 0, pulses0 = 0, pulses1 = 0;
    logic mosi_seen0 [1:16];

    always @(posedge bus0.sclk_o or posedge bus0.cs_no) begin
        if (bus0.cs_no) begin
            pulses0 = rises0;
            rises0  = 0;
        end else begin
            rises0 = rises0 + 1;
            if (rises0 >= 1 && rises0 <= 16) mosi_seen0[rises0] = bus0.mosi_o;
        end
    end

    always @(posedge bus1.sclk_o or posedge bus1.cs_no) begin
        if (bus1.cs_no) begin
            pulses1 = rises1;
            rises1  = 0;
        end else begin
            rises1 = rises1 + 1;
        end
    end

    always @(negedge bus0.sclk_o or posedge bus0.cs_no) begin
        if (bus0.cs_no)                      bus0.miso_i = 1'b0;
        else if (rises0 <= 4)                bus0.miso_i = 1'b1;
        else if (rises0 >= 6 && rises0 <= 15) bus0.miso_i = adc_val[0][15-rises0];
        else                                 bus0.miso_i = 1'b0;
    end

    always @(negedge bus1.sclk_o or posedge bus1.cs_no) begin
        if (bus1.cs_no)                      bus1.miso_i = 1'b0;
        else if (rises1 <= 4)                bus1.miso_i = 1'b1;
        else if (rises1 >= 6 && rises1 <= 15) bus1.miso_i = adc_val[1][15-rises1];
        else                                 bus1.miso_i = 1'b0;
    end

    // Timeline model: frame start cycles from the tick arithmetic; every
    // output is then a pure function of the offset into the frame.
    int         cyc = 0;
    int         tmr [2] = '{0, 0};
    int         t0 [2] = '{-1, -1};
    bit         e_ovr [2] = '{1'b0, 1'b0};
    logic [9:0] e_sig [2] = '{10'd0, 10'd0};
    logic [2:0] fch [2] = '{3'd0, 3'd0};
    logic [9:0] fval [2] = '{10'd0, 10'd0};
    int         fall0 [$];
    int         fall1 [$];
    int         samp_cnt [2] = '{0, 0};

    always @(negedge bus0.cs_no) fall0.push_back(cyc);
    always @(negedge bus1.cs_no) fall1.push_back(cyc);

    always @(posedge clk or negedge rst_n) begin
        bit busy, tick;
        int sd;
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                tmr[g] = 0; t0[g] = -1; e_ovr[g] = 1'b0; e_sig[g] = '0;
            end
        end else begin
            cyc = cyc + 1;
            for (int g = 0; g < 2; g++) begin
                sd   = (g == 0) ? SD0 : SD1;
                busy = (t0[g] >= 0) && (cyc - t0[g] >= 1) && (cyc - t0[g] <= FL + 1);
                tick = en[g] && (tmr[g] == sd - 1);
                if (t0[g] >= 0 && cyc - t0[g] == FL) e_sig[g] = fval[g];
                if (tick) begin
                    if (busy) e_ovr[g] = 1'b1;
                    else begin
                        t0[g] = cyc; fch[g] = ch[g]; fval[g] = adc_val[g];
                    end
                end
                if (!en[g]) e_ovr[g] = 1'b0;
                tmr[g] = (!en[g] || tick) ? 0 : tmr[g] + 1;
            end
        end
    end

    // Packed view: {cs, sclk, mosi, sample, overrun, signal[9:0]}
    function automatic logic [14:0] exp_out(input int g);
        int k, j, n;
        bit act, cs, sclk, mosi, smp;
        logic [2:0] c;
        k   = cyc - t0[g];
        j   = k - D;
        c   = fch[g];
        act = (t0[g] >= 0) && (k >= 0) && (k <= FL);
        cs  = !(act && k < FL);
        smp = act && (k == FL);
        sclk = act && (j >= 0) && (j < 32 * D) && (((j / D) % 2) == 0);
        if (k < D)           n = 1;
        else if (j < 32 * D) n = j / (2 * D) + 1 + (((j % (2 * D)) >= D) ? 1 : 0);
        else                 n = 17;
        if (n <= 2)      mosi = 1'b1;
        else if (n <= 5) mosi = c[5-n];
        else             mosi = 1'b0;
        mosi = mosi && !cs;
        return {cs, sclk, mosi, smp, e_ovr[g], e_sig[g]};
    endfunction

    function automatic logic [14:0] obs(input int g);
        if (g == 0)
            return {bus0.cs_no, bus0.sclk_o, bus0.mosi_o, bus0.sample_o, bus0.overrun_o,
                    bus0.signal_o};
        return {bus1.cs_no, bus1.sclk_o, bus1.mosi_o, bus1.sample_o, bus1.overrun_o,
                bus1.signal_o};
    endfunction

    task automatic chk(input string name, input int g, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s[u%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, g, cyc, act,
                     exp);
        end
    endtask

    task automatic compare_loop();
        logic [14:0] o, e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                o = obs(g);
                e = exp_out(g);
                chk("cs_no",     g, int'(o[14]),  int'(e[14]));
                chk("sclk_o",    g, int'(o[13]),  int'(e[13]));
                chk("mosi_o",    g, int'(o[12]),  int'(e[12]));
                chk("sample_o",  g, int'(o[11]),  int'(e[11]));
                chk("overrun_o", g, int'(o[10]),  int'(e[10]));
                chk("signal_o",  g, int'(o[9:0]), int'(e[9:0]));
                if (o[11]) samp_cnt[g] = samp_cnt[g] + 1;
            end
        end
    endtask

    task automatic wait_sample(input int g, input int limit);
        int n;
        logic [14:0] o;
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
            o = obs(g);
        end while (!o[11] && n < limit);
        chk("sample_wait", g, int'(o[11]), 1);
    endtask

    initial begin
        logic [14:0] o;
        logic [4:0]  mb;
        int n, nf, ns;

        fork
            compare_loop();
        join_none

        rst_n = 1'b0;
        en = '{1'b0, 1'b0};
        ch = '{3'd0, 3'd0};
        adc_val = '{10'd0, 10'd0};

        // Reset values
        repeat (5) @(negedge clk);
        o = obs(0);
        chk("rst_cs",     0, int'(o[14]),  1);
        chk("rst_sclk",   0, int'(o[13]),  0);
        chk("rst_mosi",   0, int'(o[12]),  0);
        chk("rst_sample", 0, int'(o[11]),  0);
        chk("rst_ovr",    0, int'(o[10]),  0);
        chk("rst_signal", 0, int'(o[9:0]), 0);
        rst_n = 1'b1;
        repeat (5000) @(negedge clk);
        chk("idle_no_cs", 0, fall0.size(), 0);

        // Single conversion, channel 3
        ch[0] = 3'd3;
        adc_val[0] = 10'h2A5;
        en[0] = 1'b1;
        wait_sample(0, 3000);
        o = obs(0);
        chk("single_signal", 0, int'(o[9:0]), 'h2A5);
        chk("single_latency", 0, cyc - fall0[fall0.size()-1], 136);
        chk("single_pulses", 0, pulses0, 16);
        mb = {mosi_seen0[1], mosi_seen0[2], mosi_seen0[3], mosi_seen0[4], mosi_seen0[5]};
        chk("single_mosi", 0, int'(mb), 'b11011);
        chk("single_ovr", 0, int'(o[10]), 0);

        // Periodicity
        adc_val[0] = 10'h000;
        wait_sample(0, 3000);
        o = obs(0);
        chk("period_sig0", 0, int'(o[9:0]), 'h000);
        adc_val[0] = 10'h3FF;
        wait_sample(0, 3000);
        o = obs(0);
        chk("period_sig1", 0, int'(o[9:0]), 'h3FF);
        adc_val[0] = 10'h155;
        wait_sample(0, 3000);
        o = obs(0);
        chk("period_sig2", 0, int'(o[9:0]), 'h155);
        chk("period_frames", 0, fall0.size(), 4);
        for (int i = 1; i < fall0.size(); i++)
            chk("period_spacing", 0, fall0[i] - fall0[i-1], 2500);
        en[0] = 1'b0;

        // Overrun with the fast instance
        ch[1] = 3'd5;
        adc_val[1] = 10'h1C3;
        en[1] = 1'b1;
        wait_sample(1, 300);
        o = obs(1);
        chk("ovr_set", 1, int'(o[10]), 1);
        chk("ovr_sig0", 1, int'(o[9:0]), 'h1C3);
        chk("ovr_pulses0", 1, pulses1, 16);
        adc_val[1] = 10'h2E7;
        wait_sample(1, 300);
        o = obs(1);
        chk("ovr_sig1", 1, int'(o[9:0]), 'h2E7);
        chk("ovr_pulses1", 1, pulses1, 16);
        chk("ovr_frames", 1, fall1.size(), 2);
        if (fall1.size() >= 2)
            chk("ovr_spacing", 1, fall1[fall1.size()-1] - fall1[fall1.size()-2], 200);
        en[1] = 1'b0;
        @(negedge clk);
        o = obs(1);
        chk("ovr_clear", 1, int'(o[10]), 0);

        // Enable dropped at SCLK edge 8
        ch[0] = 3'd6;
        adc_val[0] = 10'h0F0;
        en[0] = 1'b1;
        n = 0;
        while (rises0 < 8 && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("drop_reach_edge8", 0, int'(rises0 >= 8), 1);
        en[0] = 1'b0;
        ns = samp_cnt[0];
        wait_sample(0, 200);
        o = obs(0);
        chk("drop_signal", 0, int'(o[9:0]), 'h0F0);
        chk("drop_ovr", 0, int'(o[10]), 0);
        nf = fall0.size();
        repeat (3000) @(negedge clk);
        chk("drop_no_cs", 0, fall0.size(), nf);
        chk("drop_one_sample", 0, samp_cnt[0] - ns, 1);

        // Asynchronous reset at SCLK edge 10
        adc_val[0] = 10'h3C5;
        en[0] = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
        end while (rises0 < 10 && n < 3000);
        chk("arst_reach_edge10", 0, rises0, 10);
        #1;
        rst_n = 1'b0;
        #1;
        o = obs(0);
        chk("arst_cs",     0, int'(o[14]),  1);
        chk("arst_sclk",   0, int'(o[13]),  0);
        chk("arst_signal", 0, int'(o[9:0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_sample(0, 3000);
        o = obs(0);
        chk("arst_refill_sig", 0, int'(o[9:0]), 'h3C5);
        chk("arst_refill_pulses", 0, pulses0, 16);
        chk("arst_refill_latency", 0, cyc - fall0[fall0.size()-1], 136);
        en[0] = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
